// File: rtl/inverse_zig_zag_traversal_if.sv
// rtl/inverse_zig_zag_traversal_if.sv - coefficient stream and matrix read-back bundle
//
// Signals:
//   start          host -> block  one-cycle pulse, begins a new block
//   in_valid       host -> block  in_data is valid this cycle
//   in_data        host -> block  next coefficient in zig-zag order
//   in_ready       block -> host  block accepts a coefficient this cycle
//   done           block -> host  full N*N block written
//   wr_count       block -> host  coefficients accepted in the current block
//   ram_read_addr  host -> block  raster address, row*N+col
//   ram_read_data  block -> host  matrix word at ram_read_addr
interface inverse_zig_zag_traversal_if #(
  parameter int DATA_W = 8,
  parameter int N      = 8,
  parameter int ADDR_W = 2 * $clog2(N)
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_read_data;

  modport master (
    output start, in_valid, in_data, ram_read_addr,
    input  in_ready, done, wr_count, ram_read_data
  );

  modport slave (
    input  start, in_valid, in_data, ram_read_addr,
    output in_ready, done, wr_count, ram_read_data
  );
endinterface

// File: rtl/inverse_zig_zag_traversal.sv
// rtl/inverse_zig_zag_traversal.sv - writes a zig-zag coefficient stream into a raster-order matrix
//
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  asynchronous, active-low reset
//   bus    inverse_zig_zag_traversal_if.slave (stream in, status, read-back)
//
// Build option: define INVZZ_SYNC_READ_EN to register ram_read_data
// (one-cycle read latency, reset value 0); otherwise the read is combinational.
module inverse_zig_zag_traversal #(
  parameter int DATA_W = 8,
  parameter int N      = 8
) (
  input  logic clk,
  input  logic reset,
  inverse_zig_zag_traversal_if.slave bus
);
  localparam int LOG2N  = $clog2(N);
  localparam int ADDR_W = 2 * LOG2N;

  localparam logic [LOG2N-1:0] IDX_MAX = LOG2N'(N - 1);
  localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W + 1)'(N * N - 1);

  typedef enum logic {FILL, DONE} state_t;
  typedef enum logic {UP, DOWN} dir_t;

  state_t            state_q;
  dir_t              dir_q, dir_d;
  logic [LOG2N-1:0]  row_q, row_d;
  logic [LOG2N-1:0]  col_q, col_d;
  logic [ADDR_W:0]   wr_count_q;
  logic [DATA_W-1:0] mem_q [N*N];

  logic xfer;
  logic wr_en;

  assign xfer  = bus.in_valid && (state_q == FILL);
  // start takes priority over a coincident transfer: that coefficient is dropped.
  // Gating on reset keeps an asserted reset from writing on a clock edge.
  assign wr_en = xfer && !bus.start && reset;

  assign bus.in_ready = (state_q == FILL);
  assign bus.done     = (state_q == DONE);
  assign bus.wr_count = wr_count_q;

  // Zig-zag walker: next (row, col, dir) after the current position.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    dir_d = dir_q;
    if (dir_q == UP) begin
      if (col_q == IDX_MAX) begin
        row_d = row_q + LOG2N'(1);
        dir_d = DOWN;
      end else if (row_q == '0) begin
        col_d = col_q + LOG2N'(1);
        dir_d = DOWN;
      end else begin
        row_d = row_q - LOG2N'(1);
        col_d = col_q + LOG2N'(1);
      end
    end else begin
      if (row_q == IDX_MAX) begin
        col_d = col_q + LOG2N'(1);
        dir_d = UP;
      end else if (col_q == '0) begin
        row_d = row_q + LOG2N'(1);
        dir_d = UP;
      end else begin
        row_d = row_q + LOG2N'(1);
        col_d = col_q - LOG2N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      dir_q      <= UP;
      row_q      <= '0;
      col_q      <= '0;
      wr_count_q <= '0;
    end else if (bus.start) begin
      state_q    <= FILL;
      dir_q      <= UP;
      row_q      <= '0;
      col_q      <= '0;
      wr_count_q <= '0;
    end else if (xfer) begin
      wr_count_q <= wr_count_q + (ADDR_W + 1)'(1);
      row_q      <= row_d;
      col_q      <= col_d;
      dir_q      <= dir_d;
      if (wr_count_q == CNT_LAST) begin
        state_q <= DONE;
      end
    end
  end

  // Matrix storage is deliberately not reset; {row, col} is row*N+col since N is a power of two.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{row_q, col_q}] <= bus.in_data;
    end
  end

`ifdef INVZZ_SYNC_READ_EN
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[bus.ram_read_addr];
    end
  end

  assign bus.ram_read_data = rd_q;
`else
  assign bus.ram_read_data = mem_q[bus.ram_read_addr];
`endif
endmodule

// File: tb/tb_inverse_zig_zag_traversal.sv
// tb/tb_inverse_zig_zag_traversal.sv - directed self-checking bench for inverse_zig_zag_traversal
module tb_inverse_zig_zag_traversal;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   zz_addr [64];
  logic [7:0] exp_mem [64];
  logic [7:0] rd;

  inverse_zig_zag_traversal_if #(.DATA_W(8), .N(8)) bus ();

  inverse_zig_zag_traversal #(.DATA_W(8), .N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read(input int a, output logic [7:0] d);
    bus.ram_read_addr = 6'(a);
`ifdef INVZZ_SYNC_READ_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    d = bus.ram_read_data;
  endtask

  task automatic check_all(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      read(a, rd);
      if (rd !== exp_mem[a]) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int idx;
    int prev;
    checks   = 0;
    failures = 0;

    // Zig-zag order built diagonal by diagonal: even diagonals run bottom-left to top-right.
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_addr[idx] = r * 8 + (s - r); idx++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_addr[idx] = r * 8 + (s - r); idx++; end
      end
    end

    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.ram_read_addr = 6'd0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_wr_count", 32'(bus.wr_count), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Block 1: continuous stream k=0..63.
    for (int k = 0; k < 64; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(k);
      exp_mem[zz_addr[k]] = 8'(k);
      step();
      if (k == 62) begin
        check("cnt63", 32'(bus.wr_count), 32'd63);
        check("not_done_63", 32'(bus.done), 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    check("done_after_64", 32'(bus.done), 32'd1);
    check("ready_low_done", 32'(bus.in_ready), 32'd0);
    check("cnt64", 32'(bus.wr_count), 32'd64);
    read(0,  rd); check("b1_addr0",  32'(rd), 32'd0);
    read(1,  rd); check("b1_addr1",  32'(rd), 32'd1);
    read(8,  rd); check("b1_addr8",  32'(rd), 32'd2);
    read(16, rd); check("b1_addr16", 32'(rd), 32'd3);
    read(9,  rd); check("b1_addr9",  32'(rd), 32'd4);
    read(2,  rd); check("b1_addr2",  32'(rd), 32'd5);
    read(7,  rd); check("b1_addr7",  32'(rd), 32'd28);
    read(56, rd); check("b1_addr56", 32'(rd), 32'd35);
    read(63, rd); check("b1_addr63", 32'(rd), 32'd63);
    check_all("b1_all");

    // DONE ignores in_valid.
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'hFF;
      step();
      check("done_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("done_cnt_hold", 32'(bus.wr_count), 32'd64);
    check("done_still", 32'(bus.done), 32'd1);
    read(0, rd); check("done_addr0", 32'(rd), 32'd0);

    // start coincident with a transfer: coefficient dropped.
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    check("start_done_drop", 32'(bus.done), 32'd0);
    check("start_cnt0", 32'(bus.wr_count), 32'd0);
    read(0, rd); check("start_drop_addr0", 32'(rd), 32'd0);

    // Block 2: same data with in_valid toggling.
    prev = 0;
    for (int c = 0; c < 128; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.in_data = 8'(c / 2);
      step();
      if (c == 1 || c == 2 || c == 51) begin
        check("toggle_cnt", 32'(bus.wr_count), 32'((c + 2) / 2));
      end
    end
    bus.in_valid = 1'b0;
    check("toggle_done", 32'(bus.done), 32'd1);
    check("toggle_cnt64", 32'(bus.wr_count), 32'd64);
    check_all("b2_all");

    // Block 3: start after done, new pattern.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("b3_done_drop", 32'(bus.done), 32'd0);
    for (int k = 0; k < 64; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'hA0 + (k % 16));
      exp_mem[zz_addr[k]] = 8'(8'hA0 + (k % 16));
      step();
    end
    bus.in_valid = 1'b0;
    check("b3_done", 32'(bus.done), 32'd1);
    read(8, rd); check("b3_addr8", 32'(rd), 32'hA2);
    check_all("b3_all");

    // Block 4: reset after 20 transfers, then a full block.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h10 + k);
      exp_mem[zz_addr[k]] = 8'(8'h10 + k);
      step();
    end
    check("pre_reset_cnt", 32'(bus.wr_count), 32'd20);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_cnt", 32'(bus.wr_count), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_reset_cnt", 32'(bus.wr_count), 32'd0);
    for (int k = 0; k < 64; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'hC3 ^ k);
      exp_mem[zz_addr[k]] = 8'(8'hC3 ^ k);
      step();
      if (k == 0) begin
        bus.in_valid = 1'b0;
        check("post_reset_cnt1", 32'(bus.wr_count), 32'd1);
        read(0, rd); check("post_reset_addr0", 32'(rd), 32'hC3);
      end
    end
    bus.in_valid = 1'b0;
    check("b4_done", 32'(bus.done), 32'd1);
    check_all("b4_all");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inverse_zig_zag_traversal.md
Name: inverse_zig_zag_traversal

Overview:
- Receiving end of the zig-zag scan: accepts a serial stream of N*N coefficients in zig-zag order and writes each one to its raster position in an internal N*N matrix RAM.
- Asserts done once a full block has been written.
- Host reads the reconstructed raster-order matrix through ram_read_addr / ram_read_data, the same read-back interface as the forward traversal.

Parameters:
- DATA_W, 8, coefficient width in bits.
- N, 8, matrix dimension; power of two, 2..16.
- ADDR_W, 2*log2(N) (6 for N=8), RAM address width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; begins a new block, aborting any partial block.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  DATA_W  next coefficient in zig-zag order.
- in_ready  out  1  block can accept a coefficient this cycle.
- done  out  1  full N*N block written; held until start or reset.
- wr_count  out  ADDR_W+1  coefficients accepted in the current block, 0..N*N.
- ram_read_addr  in  ADDR_W  raster address, row*N+col.
- ram_read_data  out  DATA_W  RAM word at ram_read_addr.

Behaviour:
- States: FILL, DONE.
- While reset=0: state=FILL, done=0, wr_count=0, row=0, col=0, dir=UP, in_ready=1 once reset releases. RAM contents are not cleared.
- in_ready = (state==FILL). A transfer occurs when in_valid && in_ready.
- On a transfer, on the same edge:
  - write in_data to RAM[row*N+col];
  - increment wr_count;
  - advance the walker.
- Walker, dir=UP:
  - col==N-1: row+1, dir=DOWN;
  - else row==0: col+1, dir=DOWN;
  - else row-1, col+1.
- Walker, dir=DOWN:
  - row==N-1: col+1, dir=UP;
  - else col==0: row+1, dir=UP;
  - else row+1, col-1.
- Transfer that sets wr_count to N*N: state goes to DONE. done=1 and in_ready=0 from the next cycle. The walker value after the last element is don't-care and is reset on the next start.
- DONE: in_valid is ignored and no RAM writes occur. done, wr_count=N*N and the RAM hold.
- start in either state, on the next edge: state=FILL, done=0, wr_count=0, row=col=0, dir=UP.
- start coincident with a transfer: start wins and the coefficient is dropped (no write).
- start mid-block: partial block is abandoned. Previously written RAM words remain until overwritten.
- Read port: combinational, ram_read_data = RAM[ram_read_addr], valid in any state. A same-cycle write to the addressed word is visible after the edge.
- Reset asserted mid-block: immediate return to reset values; no further writes.

Optional Feature:
- Macro: INVZZ_SYNC_READ_EN.
- Defined: ram_read_data is registered, i.e. RAM[ram_read_addr] sampled at the clk edge, one-cycle latency; reset value 0.
- Undefined: combinational read as described above, zero latency.

Test Plan:
- Reset pulse, then stream in_data=k for k=0..63 with in_valid=1 continuously -> 64 transfers; done=1 the cycle after the 64th; reads give addr0=0, addr1=1, addr8=2, addr16=3, addr9=4, addr2=5, addr7=28, addr56=35, addr63=63.
- Same stream with in_valid toggled 1,0,1,0... -> identical RAM contents; wr_count increments only on valid cycles; done asserts after 64 accepted.
- In DONE, drive in_valid=1, in_data=8'hFF for 10 cycles -> in_ready=0; RAM unchanged (addr0 still 0); wr_count stays 64.
- After done, pulse start, stream in_data=8'hA0+(k%16) -> done drops the next cycle; the new block overwrites all words; addr8 reads 8'hA2.
- Assert reset (0) after 20 transfers, release, stream a full block -> wr_count restarts at 0; the first post-reset coefficient lands at addr0; final contents correct.
- With INVZZ_SYNC_READ_EN defined, repeat the first test -> each read value appears one cycle after its address is applied.
